// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_cfg
//  Description : Oversampling UART receiver with majority-vote bit recovery,
//                configurable frame format and a small receive FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    input  logic                 clr_err,
    output logic                 busy
);

    localparam int c_DIV = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int c_TW  = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_OSW = $clog2(OVERSAMPLE);
    localparam int c_AW  = $clog2(FIFO_DEPTH);
    localparam int c_WW  = DATA_BITS + 2;

    localparam logic [c_TW-1:0]  c_DIV_M1    = c_TW'(c_DIV - 1);
    localparam logic [c_OSW-1:0] c_S0        = c_OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [c_OSW-1:0] c_S1        = c_OSW'(OVERSAMPLE / 2);
    localparam logic [c_OSW-1:0] c_S2        = c_OSW'(OVERSAMPLE / 2 + 1);
    localparam logic [c_OSW-1:0] c_OS_LAST   = c_OSW'(OVERSAMPLE - 1);
    localparam logic [3:0]       c_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       c_STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [1:0]            r_sync;
    logic [1:0]            r_live;
    logic                  r_rxs_d;
    logic [c_TW-1:0]       r_tick_cnt;
    logic [c_OSW-1:0]      r_os;
    logic                  r_s0;
    logic                  r_s1;
    logic [3:0]            r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_par;
    logic                  r_fe;
    logic                  r_pe;

    logic                  w_rxs;
    logic                  w_fall;
    logic                  w_tick;
    logic                  w_vote;
    logic                  w_at_vote;
    logic                  w_at_end;
    logic                  w_push;
    logic [c_WW-1:0]       w_push_word;

    assign w_rxs       = r_sync[1];
    assign w_fall      = r_rxs_d & ~w_rxs;
    assign w_tick      = (r_tick_cnt == c_DIV_M1);
    assign w_vote      = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
    assign w_at_vote   = w_tick && (r_os == c_S2);
    assign w_at_end    = w_tick && (r_os == c_OS_LAST);
    assign w_push      = (r_state == ST_STOP) && w_at_vote && (r_bit_cnt == c_STOP_LAST);
    assign w_push_word = {r_shift, r_fe | ~w_vote, r_pe};
    assign busy        = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_sync     <= 2'b11;
            r_live     <= 2'b00;
            r_rxs_d    <= 1'b0;
            r_tick_cnt <= '0;
            r_os       <= '0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_fe       <= 1'b0;
            r_pe       <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], rx};
            r_live  <= {r_live[0], 1'b1};
            // The edge detector ignores the synchronizer's reset value so a
            // line that is low when reset lifts cannot fake a start edge.
            r_rxs_d <= r_live[1] ? w_rxs : 1'b0;

            if ((r_state == ST_IDLE && w_fall) || w_tick)
                r_tick_cnt <= '0;
            else
                r_tick_cnt <= r_tick_cnt + 1'b1;

            if (r_state == ST_IDLE) begin
                if (w_fall) begin
                    r_state   <= ST_START;
                    r_os      <= '0;
                    r_bit_cnt <= '0;
                    r_par     <= 1'b0;
                    r_fe      <= 1'b0;
                    r_pe      <= 1'b0;
                end
            end else if (w_tick) begin
                if (r_os == c_S0) r_s0 <= w_rxs;
                if (r_os == c_S1) r_s1 <= w_rxs;
                r_os <= (r_os == c_OS_LAST) ? '0 : r_os + 1'b1;

                case (r_state)
                    ST_START: begin
                        if (w_at_vote && w_vote)
                            r_state <= ST_IDLE;
                        else if (w_at_end)
                            r_state <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (w_at_vote) begin
                            r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                            r_par   <= r_par ^ w_vote;
                        end
                        if (w_at_end) begin
                            if (r_bit_cnt == c_DATA_LAST) begin
                                r_bit_cnt <= '0;
                                r_state   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (w_at_vote)
                            r_pe <= (r_par ^ w_vote) ^ (PARITY == 2);
                        if (w_at_end)
                            r_state <= ST_STOP;
                    end
                    ST_STOP: begin
                        // The final stop bit is pushed at its vote, not its end,
                        // so back-to-back frames are never missed.
                        if (w_at_vote) begin
                            if (!w_vote) r_fe <= 1'b1;
                            if (r_bit_cnt == c_STOP_LAST) r_state <= ST_IDLE;
                        end
                        if (w_at_end)
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    logic [c_WW-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW:0]   r_wr;
    logic [c_AW:0]   r_rd;
    logic            r_ovr;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_wr_en;
    logic            w_drop;
    logic [c_WW-1:0] w_head;

    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[c_AW] != r_rd[c_AW]) && (r_wr[c_AW-1:0] == r_rd[c_AW-1:0]);
    assign w_pop   = !w_empty && rx_ready;
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;
    assign w_head  = r_mem[r_rd[c_AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_ovr <= 1'b0;
        end else begin
            if (w_wr_en) r_wr <= r_wr + 1'b1;
            if (w_pop)   r_rd <= r_rd + 1'b1;
            if (w_drop)
                r_ovr <= 1'b1;
            else if (clr_err)
                r_ovr <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr[c_AW-1:0]] <= w_push_word;
    end

    assign rx_valid   = !w_empty;
    assign rx_data    = rx_valid ? w_head[c_WW-1:2] : '0;
    assign frame_err  = rx_valid & w_head[1];
    assign parity_err = rx_valid & w_head[0];
    assign overrun    = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_cfg
//  Description : Scoreboard bench for uart_rx_cfg (8N1 and 8E1 instances).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

    localparam int CLK_HZ   = 1536000;
    localparam int BAUD     = 9600;
    localparam int OS       = 16;
    localparam int DEPTH    = 4;
    localparam int BIT_CLKS = CLK_HZ / BAUD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1, rx_p = 1'b1;
    logic       rdy = 1'b1, rdy_p = 1'b1;
    logic       clr = 1'b0, clr_p = 1'b0;
    logic [7:0] d0, d1;
    logic       v0, fe0, pe0, ov0, busy0;
    logic       v1, fe1, pe1, ov1, busy1;

    uart_rx_cfg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(d0), .rx_valid(v0),
        .rx_ready(rdy), .frame_err(fe0), .parity_err(pe0), .overrun(ov0),
        .clr_err(clr), .busy(busy0));

    uart_rx_cfg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                  .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_p (
        .clk(clk), .rst_n(rst_n), .rx(rx_p), .rx_data(d1), .rx_valid(v1),
        .rx_ready(rdy_p), .frame_err(fe1), .parity_err(pe1), .overrun(ov1),
        .clr_err(clr_p), .busy(busy1));

    always #5 clk = ~clk;

    typedef struct packed {logic [7:0] d; logic fe; logic pe;} exp_t;
    exp_t q0[$];
    exp_t q1[$];
    bit   exp_ovr0 = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   vcyc0 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a frame yields its byte, a framing error when the stop
    // bit is 0, and (for even parity) an error when data^parity has odd weight.
    task automatic send(input int line, input logic [7:0] data, input bit pbit,
                        input bit stopb, input int low_after);
        exp_t e;
        logic [10:0] bits;
        int nb;
        e.d  = data;
        e.fe = ~stopb;
        e.pe = (line == 1) ? ((^data) ^ pbit) : 1'b0;
        if (line == 0) begin
            if (q0.size() < DEPTH) q0.push_back(e);
            else exp_ovr0 = 1'b1;
            bits = {1'b1, stopb, data, 1'b0};
            nb = 10;
        end else begin
            q1.push_back(e);
            bits = {stopb, pbit, data, 1'b0};
            nb = 11;
        end
        for (int i = 0; i < nb; i++) begin
            if (line == 0) rx = bits[i]; else rx_p = bits[i];
            repeat (BIT_CLKS) @(posedge clk);
            #1;
        end
        if (low_after > 0) begin
            repeat (low_after) @(posedge clk);
            #1;
        end
        if (line == 0) rx = 1'b1; else rx_p = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic       pv0 = 1'b0, prdy0 = 1'b0;
    logic [9:0] pword0 = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            pv0 = 1'b0;
        end else begin
            if (v0) vcyc0++;
            if (pv0 && !prdy0 && v0) check("dut0 hold while stalled", {d0, fe0, pe0}, pword0);
            if (v0 && rdy) begin
                if (q0.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dut0 unexpected word: got %0h expected none", d0);
                end else begin
                    e = q0.pop_front();
                    check("dut0 rx_data", d0, e.d);
                    check("dut0 frame_err", fe0, e.fe);
                    check("dut0 parity_err", pe0, e.pe);
                end
            end
            pv0 = v0; prdy0 = rdy; pword0 = {d0, fe0, pe0};
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && v1 && rdy_p) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut1 unexpected word: got %0h expected none", d1);
            end else begin
                e = q1.pop_front();
                check("dut1 rx_data", d1, e.d);
                check("dut1 frame_err", fe1, e.fe);
                check("dut1 parity_err", pe1, e.pe);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        repeat (5) @(posedge clk);
        #1;
        check("reset rx_valid", v0, 0);
        check("reset rx_data", d0, 0);
        check("reset flags", {fe0, pe0, ov0, busy0}, 0);
        check("reset dut1 outputs", {v1, fe1, pe1, ov1, busy1, d1}, 0);
        rst_n = 1'b1;
        idle(20);

        // 8N1 0xA5: exactly one valid cycle with ready held high
        vcyc0 = 0;
        send(0, 8'hA5, 1'b0, 1'b1, 0);
        idle(50);
        check("a5 valid cycles", vcyc0, 1);
        check("a5 scoreboard drained", q0.size(), 0);

        // even parity: bad then good parity bit
        send(1, 8'h03, 1'b1, 1'b1, 0);
        idle(10);
        send(1, 8'h03, 1'b0, 1'b1, 0);
        idle(50);
        check("parity scoreboard drained", q1.size(), 0);

        // framing error followed by two bit-times of low line
        vcyc0 = 0;
        send(0, 8'h55, 1'b0, 1'b0, 2 * BIT_CLKS);
        idle(400);
        check("framing single word", vcyc0, 1);
        check("framing busy idle", busy0, 0);

        // glitch shorter than half a bit
        vcyc0 = 0;
        rx = 1'b0;
        idle(30);
        check("glitch busy during", busy0, 1);
        idle(10);
        rx = 1'b1;
        idle(300);
        check("glitch busy after", busy0, 0);
        check("glitch no word", vcyc0, 0);

        // overrun: five frames into a four-entry FIFO with no consumer
        rdy = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send(0, 8'(i), 1'b0, 1'b1, 0);
            idle(10);
        end
        idle(50);
        check("overrun set", ov0, exp_ovr0);
        check("stalled head", d0, 8'h01);
        check("stalled valid", v0, 1);
        rdy = 1'b1;
        idle(20);
        check("overrun drain", q0.size(), 0);
        check("overrun sticky", ov0, 1);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        exp_ovr0 = 1'b0;
        check("overrun cleared", ov0, exp_ovr0);

        // reset during data bit 3 of a frame, then a clean frame
        rb = 8'hC6;
        rx = 1'b0;
        idle(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            rx = rb[i];
            idle(BIT_CLKS);
        end
        rx = rb[3];
        idle(BIT_CLKS / 2);
        rst_n = 1'b0;
        idle(3);
        check("midframe reset busy", busy0, 0);
        check("midframe reset valid", v0, 0);
        rst_n = 1'b1;
        rx = 1'b1;
        idle(2000);
        check("after reset quiet", {v0, busy0}, 0);
        vcyc0 = 0;
        send(0, 8'h3C, 1'b0, 1'b1, 0);
        idle(50);
        check("post reset single word", vcyc0, 1);

        // randomized traffic on both instances concurrently
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(0, 8'($urandom), 1'b0, ($urandom_range(0, 3) != 0), 0);
                    idle($urandom_range(4, 60));
                end
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    send(1, 8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 0);
                    idle($urandom_range(4, 60));
                end
            end
        join
        idle(400);
        check("random dut0 drained", q0.size(), 0);
        check("random dut1 drained", q1.size(), 0);
        check("random overrun", ov0, exp_ovr0);
        check("random dut1 overrun", ov1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
